// File: rtl/rv_defs.sv
// Shared definitions for the instruction/data memory arbiter: state encoding,
// abort data and counter widths.
package rv_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [31:0] ABORT_DATA = 32'h0;
    localparam int          STREAK_W   = 4;
    localparam int          WDOG_W     = 10;

endpackage

// File: rtl/rv_mem_arbiter.sv
// Arbitrates one single-ported memory bus between the fetch and data ports,
// with a data-priority streak limit and a watchdog abort on missing acks.
module rv_mem_arbiter
    import rv_defs::*;
#(
    parameter int G_MAX_D_STREAK = 4,
    parameter int G_TIMEOUT      = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        im_req_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic        dm_req_i,
    input  logic        dm_write_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic        err_o
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(G_MAX_D_STREAK);
    localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'(G_TIMEOUT - 1);

    arb_state_t          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                grant_i, grant_d;
    logic                busy, expired, done;

    assign busy    = (state_q != ST_IDLE);
    assign expired = busy && (wdog_q == WDOG_LAST);
    // An ack in the final watchdog cycle still counts as a normal completion.
    assign done    = busy && (mem_ack_i || expired);

    // Requester-side outputs depend only on state and the bus response, so
    // they all read zero while reset holds the FSM in IDLE.
    assign im_valid_o  = (state_q == ST_BUSY_I) && done;
    assign dm_ready_o  = (state_q == ST_BUSY_D) && done;
    assign im_data_o   = ((state_q == ST_BUSY_I) && mem_ack_i) ? mem_data_i : ABORT_DATA;
    assign dm_data_l_o = ((state_q == ST_BUSY_D) && mem_ack_i) ? mem_data_i : ABORT_DATA;
    assign err_o       = expired && !mem_ack_i;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        wdog_d   = wdog_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (dm_req_i && !(im_req_i && (streak_q == MAX_STREAK))) begin
                    grant_d = 1'b1;
                end else if (im_req_i) begin
                    grant_i = 1'b1;
                end
                if (!im_req_i || grant_i) begin
                    streak_d = '0;
                end else if (grant_d && (streak_q != MAX_STREAK)) begin
                    streak_d = streak_q + 1'b1;
                end
                if (grant_d) begin
                    state_d = ST_BUSY_D;
                end else if (grant_i) begin
                    state_d = ST_BUSY_I;
                end
            end
            default: begin
                if (done) begin
                    state_d = ST_IDLE;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            streak_q   <= '0;
            wdog_q     <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_sel_o  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            wdog_q   <= wdog_d;
            if (grant_d) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= dm_write_i;
                mem_addr_o <= dm_addr_i;
                mem_data_o <= dm_data_s_i;
                mem_sel_o  <= dm_data_select_i;
            end else if (grant_i) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= im_addr_i;
                mem_data_o <= '0;
                mem_sel_o  <= 4'hF;
            end else if (done) begin
                mem_req_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of the arbitration rules.
module tb_rv_mem_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        im_req = 1'b0;
    logic [31:0] im_addr = '0;
    logic [31:0] im_data;
    logic        im_valid;
    logic        dm_req = 1'b0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_sel = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_data = '0;
    logic        mem_ack = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;

    rv_mem_arbiter #(.G_MAX_D_STREAK(MAXS), .G_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .im_req_i(im_req), .im_addr_i(im_addr), .im_data_o(im_data), .im_valid_o(im_valid),
        .dm_req_i(dm_req), .dm_write_i(dm_write), .dm_addr_i(dm_addr),
        .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel),
        .dm_data_l_o(dm_rdata), .dm_ready_o(dm_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_sel_o(mem_sel),
        .mem_data_i(mem_data), .mem_ack_i(mem_ack), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mem_ack  = 1'b1;
        mem_data = 32'hFFFF_FFFF;
        #2;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_data got %h want 0", mem_wdata); end
        checks++; if (mem_sel !== 4'h0) begin errors++; $display("FAIL rst_mem_sel got %h want 0", mem_sel); end
        checks++; if ({im_valid, dm_ready, err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b want 000", {im_valid, dm_ready, err}); end
        checks++; if ({im_data, dm_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", {im_data, dm_rdata}); end
        mem_ack  = 1'b0;
        mem_data = 32'h0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        im_req  = 1'b1;
        im_addr = 32'h100;
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %0b want 1", mem_req); end
        checks++; if (mem_sel !== 4'hF) begin errors++; $display("FAIL fetch_sel got %h want f", mem_sel); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_we got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr got %h want 100", mem_addr); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (im_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid k=%0d got %0b want 0", k, im_valid); end
            step();
        end
        mem_ack  = 1'b1;
        mem_data = 32'h13;
        #1;
        checks++; if (im_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %0b want 1", im_valid); end
        checks++; if (im_data !== 32'h13) begin errors++; $display("FAIL fetch_data got %h want 13", im_data); end
        checks++; if ({dm_ready, err} !== 2'b00) begin errors++; $display("FAIL fetch_other got %b want 00", {dm_ready, err}); end
        step();
        mem_ack = 1'b0;
        im_req  = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop got %0b want 0", mem_req); end
        checks++; if (im_valid !== 1'b0) begin errors++; $display("FAIL fetch_single_pulse got %0b want 0", im_valid); end
        step();
    endtask

    task automatic test_store();
        dm_req   = 1'b1;
        dm_write = 1'b1;
        dm_addr  = 32'h2000;
        dm_wdata = 32'hCAFE_BABE;
        dm_sel   = 4'b0011;
        step();
        checks++; if ({mem_req, mem_we} !== 2'b11) begin errors++; $display("FAIL store_req_we got %b want 11", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h2000) begin errors++; $display("FAIL store_addr got %h want 2000", mem_addr); end
        checks++; if (mem_wdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL store_data got %h want cafebabe", mem_wdata); end
        checks++; if (mem_sel !== 4'b0011) begin errors++; $display("FAIL store_sel got %b want 0011", mem_sel); end
        checks++; if (dm_ready !== 1'b0) begin errors++; $display("FAIL store_early_ready got %0b want 0", dm_ready); end
        step();
        mem_ack = 1'b1;
        #1;
        checks++; if (dm_ready !== 1'b1) begin errors++; $display("FAIL store_ready got %0b want 1", dm_ready); end
        checks++; if ({im_valid, err} !== 2'b00) begin errors++; $display("FAIL store_other got %b want 00", {im_valid, err}); end
        step();
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        #1;
        checks++; if ({mem_req, dm_ready, im_valid} !== 3'b000) begin errors++; $display("FAIL store_after got %b want 000", {mem_req, dm_ready, im_valid}); end
        step();
    endtask

    task automatic test_contention();
        logic [31:0] want;
        im_addr  = 32'h1000;
        dm_addr  = 32'h2000;
        dm_write = 1'b0;
        im_req   = 1'b1;
        dm_req   = 1'b1;
        for (int g = 0; g < 10; g++) begin
            want = (g % 5 == 4) ? 32'h1000 : 32'h2000;
            step();
            checks++; if (mem_req !== 1'b1 || mem_addr !== want) begin errors++; $display("FAIL contention_grant g=%0d got req=%0b addr=%h want addr=%h", g, mem_req, mem_addr, want); end
            mem_ack  = 1'b1;
            mem_data = 32'(g);
            #1;
            checks++; if ({im_valid, dm_ready} !== ((want == 32'h1000) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_pulse g=%0d got %b", g, {im_valid, dm_ready}); end
            step();
            mem_ack = 1'b0;
        end
        im_req = 1'b0;
        dm_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        im_req   = 1'b1;
        im_addr  = 32'h300;
        mem_data = 32'hBAD0_BAD0;
        step();
        for (int k = 0; k < TMO; k++) begin
            if (k < TMO - 1) begin
                checks++; if ({mem_req, im_valid, err} !== 3'b100) begin errors++; $display("FAIL timeout_wait k=%0d got %b want 100", k, {mem_req, im_valid, err}); end
            end else begin
                checks++; if ({im_valid, err} !== 2'b11) begin errors++; $display("FAIL timeout_abort got %b want 11", {im_valid, err}); end
                checks++; if (im_data !== 32'h0) begin errors++; $display("FAIL timeout_data got %h want 0", im_data); end
            end
            step();
        end
        im_req = 1'b0;
        #1;
        checks++; if ({mem_req, im_valid, err} !== 3'b000) begin errors++; $display("FAIL timeout_after got %b want 000", {mem_req, im_valid, err}); end
        step();
        mem_ack  = 1'b1;
        mem_data = 32'hDEAD;
        #1;
        checks++; if ({mem_req, im_valid, dm_ready, err} !== 4'b0000) begin errors++; $display("FAIL late_ack got %b want 0000", {mem_req, im_valid, dm_ready, err}); end
        step();
        mem_ack = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL late_ack_idle got %0b want 0", mem_req); end
        step();
    endtask

    task automatic test_ack_timeout();
        dm_req   = 1'b1;
        dm_write = 1'b0;
        dm_addr  = 32'h400;
        step();
        for (int k = 0; k < TMO - 1; k++) step();
        mem_ack  = 1'b1;
        mem_data = 32'h55;
        #1;
        checks++; if ({dm_ready, err} !== 2'b10) begin errors++; $display("FAIL coincide_flags got %b want 10", {dm_ready, err}); end
        checks++; if (dm_rdata !== 32'h55) begin errors++; $display("FAIL coincide_data got %h want 55", dm_rdata); end
        step();
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        #1;
        checks++; if ({mem_req, err} !== 2'b00) begin errors++; $display("FAIL coincide_after got %b want 00", {mem_req, err}); end
        step();
    endtask

    task automatic test_reset_busy();
        logic [31:0] want;
        im_addr = 32'h1000;
        dm_addr = 32'h2000;
        im_req  = 1'b1;
        dm_req  = 1'b1;
        for (int g = 0; g < 2; g++) begin
            step();
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin errors++; $display("FAIL rbusy_grant got req=%0b addr=%h want 1 2000", mem_req, mem_addr); end
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        #1;
        checks++; if ({mem_req, dm_ready} !== 2'b00) begin errors++; $display("FAIL rbusy_async got %b want 00", {mem_req, dm_ready}); end
        step();
        checks++; if ({mem_req, dm_ready, im_valid} !== 3'b000) begin errors++; $display("FAIL rbusy_held got %b want 000", {mem_req, dm_ready, im_valid}); end
        mem_ack = 1'b0;
        rst_n   = 1'b1;
        for (int g = 0; g < 5; g++) begin
            want = (g == 4) ? 32'h1000 : 32'h2000;
            step();
            checks++; if (mem_req !== 1'b1 || mem_addr !== want) begin errors++; $display("FAIL rbusy_streak g=%0d got addr=%h want %h", g, mem_addr, want); end
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        im_req = 1'b0;
        dm_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        int          m_streak;
        int          lat;
        bit          exp_d;
        bit          fin;
        logic [31:0] rd;
        logic [31:0] exp_data;
        m_streak = 0;
        for (int t = 0; t < 150; t++) begin
            if (!im_req && $urandom_range(0, 1) == 1) begin
                im_req  = 1'b1;
                im_addr = $urandom;
            end
            if (!dm_req && $urandom_range(0, 1) == 1) begin
                dm_req   = 1'b1;
                dm_write = 1'($urandom_range(0, 1));
                dm_addr  = $urandom;
                dm_wdata = $urandom;
                dm_sel   = 4'($urandom);
            end
            mem_ack  = ($urandom_range(0, 3) == 0);
            mem_data = $urandom;
            #1;
            checks++; if ({im_valid, dm_ready, err} !== 3'b000) begin errors++; $display("FAIL rnd_idle_ack t=%0d got %b want 000", t, {im_valid, dm_ready, err}); end
            if (!im_req && !dm_req) begin
                m_streak = 0;
                step();
                mem_ack = 1'b0;
                checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rnd_no_req t=%0d got %0b want 0", t, mem_req); end
                continue;
            end
            exp_d = dm_req && !(im_req && m_streak == MAXS);
            if (!im_req || !exp_d) m_streak = 0;
            else if (m_streak < MAXS) m_streak = m_streak + 1;
            step();
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rnd_req t=%0d got %0b want 1", t, mem_req); end
            checks++; if (mem_addr !== (exp_d ? dm_addr : im_addr)) begin errors++; $display("FAIL rnd_addr t=%0d got %h want %h", t, mem_addr, exp_d ? dm_addr : im_addr); end
            checks++; if (mem_we !== (exp_d ? dm_write : 1'b0) || mem_sel !== (exp_d ? dm_sel : 4'hF)) begin errors++; $display("FAIL rnd_we_sel t=%0d got %0b/%h", t, mem_we, mem_sel); end
            if (exp_d && dm_write) begin
                checks++; if (mem_wdata !== dm_wdata) begin errors++; $display("FAIL rnd_wdata t=%0d got %h want %h", t, mem_wdata, dm_wdata); end
            end
            lat = $urandom_range(0, 10);
            fin = 1'b0;
            for (int k = 0; k < TMO && !fin; k++) begin
                rd = $urandom;
                mem_ack  = (k == lat);
                mem_data = rd;
                #1;
                if (k == lat || k == TMO - 1) begin
                    exp_data = (k == lat) ? rd : 32'h0;
                    checks++; if ({im_valid, dm_ready, err} !== {!exp_d, exp_d, k != lat}) begin errors++; $display("FAIL rnd_done t=%0d k=%0d got %b want %b", t, k, {im_valid, dm_ready, err}, {!exp_d, exp_d, k != lat}); end
                    if (!exp_d) begin
                        checks++; if (im_data !== exp_data) begin errors++; $display("FAIL rnd_idata t=%0d got %h want %h", t, im_data, exp_data); end
                    end else if (!dm_write) begin
                        checks++; if (dm_rdata !== exp_data) begin errors++; $display("FAIL rnd_ddata t=%0d got %h want %h", t, dm_rdata, exp_data); end
                    end
                    fin = 1'b1;
                end else begin
                    checks++; if ({mem_req, im_valid, dm_ready, err} !== 4'b1000) begin errors++; $display("FAIL rnd_wait t=%0d k=%0d got %b want 1000", t, k, {mem_req, im_valid, dm_ready, err}); end
                end
                step();
            end
            mem_ack = 1'b0;
            if (exp_d) dm_req = 1'b0;
            else im_req = 1'b0;
            #1;
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rnd_release t=%0d got %0b want 0", t, mem_req); end
        end
        im_req  = 1'b0;
        dm_req  = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_timeout();
        test_ack_timeout();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit got running want finished");
        $fatal(1, "time limit");
    end

endmodule
